router_mport: RTL and testbench

Store-and-forward packet router: the parametrised successor of the single-port byte router. It accepts one byte-serial packet at a time, buffers it, and checks size, length field, destination and checksum. Good packets go out on one of `NUM_PORTS` output channels selected by the destination byte, with per-port ready back-pressure. Bad packets are dropped with an error code, and statistics counters are exported. It sits between the packet generator/driver and the per-port sinks in the router testbench hierarchy.

---
 rtl/router_mport.sv | 203 ++++++++++++++++++++
 tb/tb_router_mport.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_mport.sv
// router_mport: store-and-forward byte router with NUM_PORTS output channels.
// Ports: clk, reset (sync, active-high); dut_inp/inp_valid serial input; per-port dut_outp/outp_valid/outp_ready;
//        busy, error code, and pkt_in/pkt_out/drop statistics counters.
// Latency: verdict 2 edges after the last input byte; first output byte 3 edges after. A byte advances only on valid&ready.
module router_mport #(
    parameter int NUM_PORTS = 4,
    parameter int MIN_PKT   = 12,
    parameter int MAX_PKT   = 2000,
    parameter int BUF_DEPTH = 2048
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             dut_inp,
    input  logic                   inp_valid,
    output logic [8*NUM_PORTS-1:0] dut_outp,
    output logic [NUM_PORTS-1:0]   outp_valid,
    input  logic [NUM_PORTS-1:0]   outp_ready,
    output logic                   busy,
    output logic [3:0]             error,
    output logic [31:0]            pkt_in_count,
    output logic [31:0]            pkt_out_count,
    output logic [31:0]            drop_count
);
    // Byte count must hold MAX_PKT+1, the saturation value that marks an oversize packet.
    localparam int CNT_W  = $clog2(MAX_PKT + 2);
    localparam int ADDR_W = $clog2(BUF_DEPTH);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_PKT);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PKT);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_SEND} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        dest_q, dest_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       csum_fld_q, csum_fld_d;
    logic [31:0]       csum_acc_q, csum_acc_d;
    logic              out_vld_q, out_vld_d;
    logic [7:0]        out_dat_q, out_dat_d;
    logic [3:0]        error_q, error_d;
    logic [31:0]       in_cnt_q, in_cnt_d;
    logic [31:0]       out_cnt_q, out_cnt_d;
    logic [31:0]       drop_q, drop_d;

    logic [7:0]        mem [BUF_DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              sel_rdy;
    logic [3:0]        verdict;

    assign busy          = (state_q == S_CHECK) || (state_q == S_SEND);
    assign error         = error_q;
    assign pkt_in_count  = in_cnt_q;
    assign pkt_out_count = out_cnt_q;
    assign drop_count    = drop_q;

    // Ready of the port addressed by the buffered destination byte.
    always_comb begin
        sel_rdy = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (dest_q == 8'(p)) sel_rdy = outp_ready[p];
        end
    end

    // Only the selected port carries data, and only while its byte is valid.
    always_comb begin
        dut_outp   = '0;
        outp_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_vld_q && (dest_q == 8'(p))) begin
                outp_valid[p]      = 1'b1;
                dut_outp[8*p +: 8] = out_dat_q;
            end
        end
    end

    // Check priority: size, length field, destination, checksum.
    always_comb begin
        if (cnt_q < MIN_C)                 verdict = 4'd3;
        else if (cnt_q > MAX_C)            verdict = 4'd4;
        else if (len_q != 32'(cnt_q))      verdict = 4'd5;
        else if (dest_q >= 8'(NUM_PORTS))  verdict = 4'd6;
        else if (csum_fld_q != csum_acc_q) verdict = 4'd2;
        else                               verdict = 4'd0;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        dest_d     = dest_q;
        len_d      = len_q;
        csum_fld_d = csum_fld_q;
        csum_acc_d = csum_acc_q;
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        error_d    = error_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        mem_waddr  = ADDR_W'(cnt_q);

        // Input while busy is dropped; the packet in flight carries on.
        if (busy && inp_valid) error_d = 4'd1;

        case (state_q)
            S_IDLE: begin
                if (inp_valid) begin
                    mem_we     = 1'b1;
                    mem_waddr  = '0;
                    dest_d     = dut_inp;
                    cnt_d      = CNT_W'(1);
                    len_d      = '0;
                    csum_fld_d = '0;
                    csum_acc_d = '0;
                    error_d    = 4'd0;
                    state_d    = S_RECV;
                end
            end
            S_RECV: begin
                if (inp_valid) begin
                    if (cnt_q < MAX_C) mem_we = 1'b1;
                    if (cnt_q <= MAX_C) cnt_d = cnt_q + 1'b1;
                    // cnt_q is the index of the byte arriving now; header fields shift in MSB first.
                    if (cnt_q >= CNT_W'(2) && cnt_q <= CNT_W'(5))
                        len_d = {len_q[23:0], dut_inp};
                    else if (cnt_q >= CNT_W'(6) && cnt_q <= CNT_W'(9))
                        csum_fld_d = {csum_fld_q[23:0], dut_inp};
                    else if (cnt_q >= CNT_W'(10))
                        csum_acc_d = csum_acc_q + {24'h0, dut_inp};
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                in_cnt_d = in_cnt_q + 32'd1;
                if (verdict != 4'd0) begin
                    error_d = verdict;
                    drop_d  = drop_q + 32'd1;
                    state_d = S_IDLE;
                end else begin
                    rd_ptr_d = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // Load a new byte when the output is empty or the current one is taken.
                if (!out_vld_q || sel_rdy) begin
                    if (rd_ptr_q == cnt_q) begin
                        out_vld_d = 1'b0;
                        out_dat_d = 8'h0;
                        out_cnt_d = out_cnt_q + 32'd1;
                        state_d   = S_IDLE;
                    end else begin
                        out_vld_d = 1'b1;
                        out_dat_d = mem[ADDR_W'(rd_ptr_q)];
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            dest_q     <= '0;
            len_q      <= '0;
            csum_fld_q <= '0;
            csum_acc_q <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            error_q    <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            dest_q     <= dest_d;
            len_q      <= len_d;
            csum_fld_q <= csum_fld_d;
            csum_acc_q <= csum_acc_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            error_q    <= error_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            drop_q     <= drop_d;
        end
    end

    // Packet buffer; contents are only read back at addresses written by the current packet.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= dut_inp;
    end
endmodule

// File: tb/tb_router_mport.sv
module tb_router_mport;
    localparam int NP   = 4;
    localparam int MINP = 12;
    localparam int MAXP = 2000;
    localparam int BUFD = 2048;

    typedef logic [7:0] bq_t [$];

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        dut_inp = 8'h0;
    logic              inp_valid = 1'b0;
    logic [8*NP-1:0]   dut_outp;
    logic [NP-1:0]     outp_valid;
    logic [NP-1:0]     outp_ready = '1;
    logic              busy;
    logic [3:0]        error;
    logic [31:0]       pkt_in_count, pkt_out_count, drop_count;

    int total = 0;
    int bad = 0;
    int ready_mode = 0;
    bit chk_en = 1'b0;
    logic [7:0] exp_q [$];
    int exp_port = 0;
    int acc_cnt = 0;
    int m_in = 0, m_out = 0, m_drop = 0, m_err = 0;
    int exp_codes [5] = '{2, 3, 4, 5, 6};

    always #5 clk = ~clk;

    router_mport #(.NUM_PORTS(NP), .MIN_PKT(MINP), .MAX_PKT(MAXP), .BUF_DEPTH(BUFD)) dut (
        .clk(clk), .reset(reset), .dut_inp(dut_inp), .inp_valid(inp_valid),
        .dut_outp(dut_outp), .outp_valid(outp_valid), .outp_ready(outp_ready),
        .busy(busy), .error(error), .pkt_in_count(pkt_in_count),
        .pkt_out_count(pkt_out_count), .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Packet-level reference verdict.
    function automatic int model_verdict(input bq_t p);
        int n;
        logic [31:0] len, fld, sum;
        n = p.size();
        if (n < MINP) return 3;
        if (n > MAXP) return 4;
        len = {p[2], p[3], p[4], p[5]};
        if (len != 32'(n)) return 5;
        if (int'(p[0]) >= NP) return 6;
        sum = 0;
        for (int i = 10; i < n; i++) sum = sum + 32'(p[i]);
        fld = {p[6], p[7], p[8], p[9]};
        if (sum != fld) return 2;
        return 0;
    endfunction

    // pmode: 0 = payload 1,2,3..; 1 = all 0xFF; else random.
    task automatic build(input int dest, input int n, input int pmode, input int len_adj,
                         input int cs_adj, output bq_t pkt);
        logic [31:0] sum, len;
        pkt = {};
        sum = 0;
        for (int i = 0; i < n; i++) pkt.push_back(8'h0);
        pkt[0] = 8'(dest);
        pkt[1] = 8'($urandom_range(0, 255));
        for (int i = 10; i < n; i++) begin
            case (pmode)
                0:       pkt[i] = 8'(i - 9);
                1:       pkt[i] = 8'hFF;
                default: pkt[i] = 8'($urandom_range(0, 255));
            endcase
            sum = sum + 32'(pkt[i]);
        end
        len = 32'(n + len_adj);
        sum = sum + 32'(cs_adj);
        pkt[2] = len[31:24]; pkt[3] = len[23:16]; pkt[4] = len[15:8]; pkt[5] = len[7:0];
        pkt[6] = sum[31:24]; pkt[7] = sum[23:16]; pkt[8] = sum[15:8]; pkt[9] = sum[7:0];
    endtask

    // Sink ready pattern: 0 = always ready, 1 = toggle every cycle, else random.
    initial begin
        bit tog;
        tog = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: outp_ready = '1;
                1: begin tog = ~tog; outp_ready = tog ? '1 : '0; end
                default: outp_ready = NP'($urandom_range(0, (1 << NP) - 1));
            endcase
        end
    end

    // Per-cycle output checker against the expected byte stream.
    initial begin
        bit hold, ok;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!chk_en) begin
                hold = 1'b0;
            end else begin
                ok = 1'b1;
                for (int p = 0; p < NP; p++) begin
                    if (!outp_valid[p] && dut_outp[8*p +: 8] != 8'h0) ok = 1'b0;
                    if (outp_valid[p] && (exp_q.size() == 0 || p != exp_port)) ok = 1'b0;
                end
                chk("port_quiet", ok, 1);
                if (exp_q.size() > 0) begin
                    if (hold) chk("hold_valid", outp_valid[exp_port], 1);
                    if (outp_valid[exp_port]) begin
                        chk("out_byte", dut_outp[8*exp_port +: 8], exp_q[0]);
                        if (outp_ready[exp_port]) begin
                            void'(exp_q.pop_front());
                            acc_cnt++;
                            hold = 1'b0;
                        end else begin
                            hold = 1'b1;
                        end
                    end
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic do_reset_mid();
        @(posedge clk); #1;
        reset = 1'b1;
        chk_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_in = 0; m_out = 0; m_drop = 0; m_err = 0;
        @(negedge clk);
        chk("rst_vld", outp_valid, 0);
        chk("rst_dat", dut_outp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", error, 0);
        chk("rst_in", pkt_in_count, 0);
        chk("rst_out", pkt_out_count, 0);
        chk("rst_drop", drop_count, 0);
        chk_en = 1'b1;
    endtask

    task automatic run_pkt(input bq_t pkt, input int mode, input bit viol, input int rst_after);
        int n, code, first_vld, vcyc, viol_st;
        bit prev_vld, any_vld, finished;
        n = pkt.size();
        code = model_verdict(pkt);
        first_vld = -1; vcyc = 0; viol_st = viol ? 1 : 0;
        prev_vld = 1'b0; finished = 1'b0;
        ready_mode = mode;
        acc_cnt = 0;
        m_in++;
        m_err = 0;
        if (code == 0) begin
            exp_port = int'(pkt[0]);
            foreach (pkt[i]) exp_q.push_back(pkt[i]);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            inp_valid = 1'b1;
            dut_inp = pkt[i];
        end
        @(posedge clk); #1;               // edge T samples the last byte
        inp_valid = 1'b0;
        dut_inp = 8'h0;
        @(negedge clk);
        chk("busy_T", busy, 0);
        @(negedge clk);
        chk("busy_T1", busy, 1);
        @(negedge clk);                   // after T+2: verdict
        chk("pkt_in_count", pkt_in_count, m_in);
        if (code != 0) begin
            m_drop++;
            m_err = code;
            chk("drop_busy", busy, 0);
            chk("drop_err", error, code);
            chk("drop_count", drop_count, m_drop);
            chk("drop_vld", outp_valid, 0);
        end else begin
            chk("send_entry_vld", outp_valid, 0);
            chk("send_busy", busy, 1);
            if (viol) m_err = 1;
            for (int k = 3; k < 4 * n + 40 && !finished; k++) begin
                @(posedge clk); #1;
                if (viol_st == 2) begin
                    inp_valid = 1'b1; dut_inp = 8'h5A; viol_st = 3;
                end else if (viol_st == 3) begin
                    inp_valid = 1'b0; dut_inp = 8'h0; viol_st = 0;
                end
                @(negedge clk);
                any_vld = |outp_valid;
                if (any_vld) begin
                    vcyc++;
                    if (first_vld < 0) begin
                        first_vld = k;
                        if (viol_st == 1) viol_st = 2;
                    end
                end
                if (rst_after > 0 && acc_cnt >= rst_after) begin
                    do_reset_mid();
                    return;
                end
                if (!busy) begin
                    finished = 1'b1;
                    chk("end_vld_fall", any_vld, 0);
                    chk("end_prev_vld", prev_vld, 1);
                    chk("end_queue", exp_q.size(), 0);
                end
                prev_vld = any_vld;
            end
            chk("send_done_in_time", finished, 1);
            m_out++;
            chk("first_byte_T3", first_vld, 3);
            if (mode == 0) chk("burst_len", vcyc, n);
            chk("pkt_out_count", pkt_out_count, m_out);
            chk("send_err", error, m_err);
            chk("send_drop", drop_count, m_drop);
        end
    endtask

    initial begin
        bq_t p;
        int dest, n, corrupt, mode;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vld", outp_valid, 0);
        chk("reset_dat", dut_outp, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err", error, 0);
        chk("reset_in", pkt_in_count, 0);
        chk("reset_out", pkt_out_count, 0);
        chk("reset_drop", drop_count, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_en = 1'b1;

        // Good packet to port 2, with the model pinned to hand-computed values.
        build(2, 16, 0, 0, 0, p);
        chk("model_csum16", p[9], 21);
        chk("model_len16", p[5], 16);
        chk("model_good16", model_verdict(p), 0);
        run_pkt(p, 0, 1'b0, 0);
        chk("good_in", pkt_in_count, 1);
        chk("good_out", pkt_out_count, 1);
        chk("good_err", error, 0);

        // One packet per drop cause.
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: build(2, 16, 0, 0, 1, p);
                1: build(1, 11, 0, 0, 0, p);
                2: build(1, 2001, 2, 0, 0, p);
                3: build(1, 16, 0, 4, 0, p);
                default: build(7, 16, 0, 0, 0, p);
            endcase
            chk("model_code", model_verdict(p), exp_codes[k]);
            run_pkt(p, 0, 1'b0, 0);
        end
        chk("drops_total", drop_count, 5);

        // Back-pressure on port 1.
        build(1, 30, 2, 0, 0, p);
        run_pkt(p, 1, 1'b0, 0);

        // Protocol violation during SEND.
        build(3, 20, 2, 0, 0, p);
        run_pkt(p, 0, 1'b1, 0);
        chk("viol_err", error, 1);

        // Boundary sizes.
        build(0, MINP, 0, 0, 0, p);
        run_pkt(p, 0, 1'b0, 0);
        build(0, MAXP, 1, 0, 0, p);
        chk("model_csum_ff", {p[6], p[7], p[8], p[9]}, 32'd507450);
        run_pkt(p, 0, 1'b0, 0);

        // Reset after five output bytes, then a clean packet.
        build(2, 40, 2, 0, 0, p);
        run_pkt(p, 0, 1'b0, 5);
        build(2, 16, 0, 0, 0, p);
        run_pkt(p, 0, 1'b0, 0);
        chk("post_rst_in", pkt_in_count, 1);
        chk("post_rst_out", pkt_out_count, 1);

        // Randomized traffic.
        for (int r = 0; r < 25; r++) begin
            dest = $urandom_range(0, 5);
            n = $urandom_range(11, 60);
            corrupt = $urandom_range(0, 7);
            mode = $urandom_range(0, 2);
            build(dest, n, 2, (corrupt == 1) ? 1 : 0, (corrupt == 2) ? 3 : 0, p);
            run_pkt(p, mode, 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
